// File: rtl/pc060ha_master_sequencer.sv
// ============================================================================
// pc060ha_master_sequencer
// Master-side PC060HA bus sequencer: byte host handshakes <-> nibble mailbox
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc060ha_master_sequencer #(
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_INTERVAL = 16,
  parameter int RESET_HOLD    = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TX_VALID,
  input  logic [7:0] TX_DATA,
  output logic       TX_READY,
  output logic       RX_VALID,
  output logic [7:0] RX_DATA,
  input  logic       RX_READY,
  input  logic       SRST_REQ,
  output logic       BUSY,
  output logic       nMCS,
  output logic       nMRD,
  output logic       nMWR,
  output logic       MA0,
  output logic [3:0] MD_OUT,
  output logic       MD_OE,
  input  logic [3:0] MD_IN
);

  localparam int CW = $clog2(STROBE_CYCLES + 3);
  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int WW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [CW-1:0] C_CYC_SAMPLE = CW'(STROBE_CYCLES);
  localparam logic [CW-1:0] C_CYC_LAST   = CW'(STROBE_CYCLES + 2);
  localparam logic [PW-1:0] C_POLL_LAST  = PW'(POLL_INTERVAL - 1);
  localparam logic [WW-1:0] C_WAIT_LAST  = WW'(RESET_HOLD - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POLL,
    ST_RX_LO,
    ST_RX_HI,
    ST_TX_LO,
    ST_TX_HI,
    ST_SR_SET,
    ST_SR_WAIT,
    ST_SR_CLR
  } state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;       // 0: page write, 1: data op
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [7:0]      tx_buf_q, tx_buf_d;
  logic            tx_full_q, tx_full_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [3:0]      lo_q, lo_d;
  logic [3:0]      rd_q, rd_d;
  logic            sticky_q, sticky_d;
  logic            tx_half_q, tx_half_d;
  logic            rx_half_q, rx_half_d;

  logic            acc;
  logic [2:0]      page;
  logic            data_wr;
  logic [3:0]      data_val;
  logic            op_wr;
  logic [3:0]      op_val;
  logic            op_on;
  logic            strobe;
  logic            op_end;
  logic            sample;

  // Per-state access descriptor: which page, and whether the data op writes.
  always_comb begin
    acc      = 1'b0;
    page     = 3'd4;
    data_wr  = 1'b0;
    data_val = 4'd0;
    case (state_q)
      ST_POLL: begin
        acc  = 1'b1;
        page = 3'd4;
      end
      ST_RX_LO: begin
        acc  = 1'b1;
        page = rx_half_q ? 3'd2 : 3'd0;
      end
      ST_RX_HI: begin
        acc  = 1'b1;
        page = rx_half_q ? 3'd3 : 3'd1;
      end
      ST_TX_LO: begin
        acc      = 1'b1;
        page     = tx_half_q ? 3'd2 : 3'd0;
        data_wr  = 1'b1;
        data_val = tx_buf_q[3:0];
      end
      ST_TX_HI: begin
        acc      = 1'b1;
        page     = tx_half_q ? 3'd3 : 3'd1;
        data_wr  = 1'b1;
        data_val = tx_buf_q[7:4];
      end
      ST_SR_SET: begin
        acc      = 1'b1;
        page     = 3'd4;
        data_wr  = 1'b1;
        data_val = 4'd1;
      end
      ST_SR_CLR: begin
        acc      = 1'b1;
        page     = 3'd4;
        data_wr  = 1'b1;
        data_val = 4'd0;
      end
      default: ;
    endcase
  end

  assign op_wr  = ~phase_q | data_wr;
  assign op_val = phase_q ? data_val : {1'b0, page};
  assign op_on  = acc && (cyc_q != C_CYC_LAST);
  assign strobe = acc && (cyc_q != '0) && (cyc_q <= C_CYC_SAMPLE);
  assign op_end = acc && phase_q && (cyc_q == C_CYC_LAST);
  assign sample = acc && phase_q && !data_wr && (cyc_q == C_CYC_SAMPLE);

  assign nMCS     = ~op_on;
  assign nMWR     = ~(strobe & op_wr);
  assign nMRD     = ~(strobe & ~op_wr);
  assign MA0      = op_on & phase_q;
  assign MD_OUT   = (op_on && op_wr) ? op_val : 4'd0;
  assign MD_OE    = op_on & op_wr;
  assign BUSY     = (state_q != ST_IDLE);
  assign TX_READY = ~tx_full_q;
  assign RX_VALID = rx_valid_q;
  assign RX_DATA  = rx_data_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cyc_d      = cyc_q;
    poll_cnt_d = poll_cnt_q;
    wait_d     = wait_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    lo_d       = lo_q;
    rd_d       = rd_q;
    sticky_d   = sticky_q;
    tx_half_d  = tx_half_q;
    rx_half_d  = rx_half_q;

    if (TX_VALID && !tx_full_q) begin
      tx_buf_d  = TX_DATA;
      tx_full_d = 1'b1;
    end
    if (rx_valid_q && RX_READY) begin
      rx_valid_d = 1'b0;
    end
    if (sample) begin
      rd_d = MD_IN;
    end

    // Cycle/phase sequencing shared by every two-op access state.
    if (acc) begin
      if (cyc_q == C_CYC_LAST) begin
        cyc_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if ((poll_cnt_q >= C_POLL_LAST) && (tx_full_q || !rx_valid_q || sticky_q)) begin
          state_d    = ST_POLL;
          poll_cnt_d = '0;
        end else if (poll_cnt_q < C_POLL_LAST) begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      ST_POLL: begin
        if (op_end) begin
          // rd_q holds status {slave_full, slave_half, master_full, master_half}
          if (sticky_q) begin
            state_d = ST_SR_SET;
          end else if (!rx_valid_q && (rx_half_q ? rd_q[3] : rd_q[2])) begin
            state_d = ST_RX_LO;
          end else if (tx_full_q && !(tx_half_q ? rd_q[1] : rd_q[0])) begin
            state_d = ST_TX_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RX_LO: begin
        if (op_end) begin
          lo_d    = rd_q;
          state_d = ST_RX_HI;
        end
      end
      ST_RX_HI: begin
        if (op_end) begin
          rx_data_d  = {rd_q, lo_q};
          rx_valid_d = 1'b1;
          rx_half_d  = ~rx_half_q;
          state_d    = ST_IDLE;
        end
      end
      ST_TX_LO: begin
        if (op_end) begin
          state_d = ST_TX_HI;
        end
      end
      ST_TX_HI: begin
        if (op_end) begin
          tx_full_d = 1'b0;
          tx_half_d = ~tx_half_q;
          state_d   = ST_IDLE;
        end
      end
      ST_SR_SET: begin
        if (op_end) begin
          wait_d  = '0;
          state_d = ST_SR_WAIT;
        end
      end
      ST_SR_WAIT: begin
        if (wait_q == C_WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_SR_CLR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_SR_CLR: begin
        if (op_end) begin
          sticky_d  = 1'b0;
          tx_half_d = 1'b0;
          rx_half_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A request arriving as the reset sequence finishes must not be lost.
    if (SRST_REQ) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      cyc_q      <= '0;
      poll_cnt_q <= '0;
      wait_q     <= '0;
      tx_buf_q   <= 8'd0;
      tx_full_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      lo_q       <= 4'd0;
      rd_q       <= 4'd0;
      sticky_q   <= 1'b0;
      tx_half_q  <= 1'b0;
      rx_half_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cyc_q      <= cyc_d;
      poll_cnt_q <= poll_cnt_d;
      wait_q     <= wait_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      lo_q       <= lo_d;
      rd_q       <= rd_d;
      sticky_q   <= sticky_d;
      tx_half_q  <= tx_half_d;
      rx_half_q  <= rx_half_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc060ha_master_sequencer.sv
// ============================================================================
// tb_pc060ha_master_sequencer
// Bench with a PC060HA slave-side model and an ordered bus-access scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc060ha_master_sequencer;

  localparam int S    = 2;
  localparam int HOLD = 64;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       TX_VALID = 1'b0;
  logic [7:0] TX_DATA = 8'd0;
  logic       TX_READY;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic       RX_READY = 1'b0;
  logic       SRST_REQ = 1'b0;
  logic       BUSY;
  logic       nMCS, nMRD, nMWR, MA0;
  logic [3:0] MD_OUT;
  logic       MD_OE;
  logic [3:0] MD_IN;

  int n_pass  = 0;
  int n_total = 0;

  // Slave model: page register, status nibble and mailbox nibbles.
  logic [3:0] status = 4'd0;
  logic [3:0] nib [4];
  logic [3:0] page_m = 4'd0;

  // Scoreboard entries: {page[2:0], write, nibble}
  logic [7:0] sb [$];
  int poll_count = 0;
  int data_ops   = 0;

  logic       in_op = 1'b0;
  int         op_len, op_strb;
  logic       op_ma0, op_wr, op_rd, op_setup_bad;
  logic [3:0] op_md, op_rdata;
  logic [7:0] got, expv;

  pc060ha_master_sequencer #(
    .STROBE_CYCLES(S),
    .POLL_INTERVAL(16),
    .RESET_HOLD(HOLD)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
    .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
    .SRST_REQ(SRST_REQ), .BUSY(BUSY),
    .nMCS(nMCS), .nMRD(nMRD), .nMWR(nMWR), .MA0(MA0),
    .MD_OUT(MD_OUT), .MD_OE(MD_OE), .MD_IN(MD_IN)
  );

  always #5 CLK = ~CLK;

  assign MD_IN = (page_m == 4'd4) ? status : nib[page_m[1:0]];

  // Bus monitor: checks op shape and feeds non-poll data accesses to the scoreboard.
  always @(negedge CLK) begin
    if (RESET) begin
      in_op = 1'b0;
    end else if (!nMCS) begin
      if (!in_op) begin
        in_op        = 1'b1;
        op_len       = 0;
        op_strb      = 0;
        op_ma0       = MA0;
        op_md        = MD_OUT;
        op_wr        = 1'b0;
        op_rd        = 1'b0;
        op_setup_bad = !nMWR || !nMRD;
      end
      op_len++;
      if (!nMWR) begin op_wr = 1'b1; op_strb++; end
      if (!nMRD) begin op_rd = 1'b1; op_strb++; op_rdata = MD_IN; end
    end else if (in_op) begin
      in_op = 1'b0;
      n_total++;
      if (op_len == S + 2 && op_strb == S && !op_setup_bad && (op_wr ^ op_rd))
        n_pass++;
      else
        $display("FAIL bus_op_shape: len=%0d strobes=%0d setup_strobe=%0b wr=%0b rd=%0b, required len=%0d strobes=%0d",
                 op_len, op_strb, op_setup_bad, op_wr, op_rd, S + 2, S);
      if (!op_ma0) begin
        if (op_wr) page_m = op_md;
      end else if (page_m == 4'd4 && op_rd) begin
        poll_count++;
      end else begin
        data_ops++;
        got = {page_m[2:0], op_wr, (op_wr ? op_md : op_rdata)};
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL scoreboard_unexpected: got page=%0d wr=%0b nib=%h, required no access", got[7:5], got[4], got[3:0]);
        end else begin
          expv = sb.pop_front();
          if (got !== expv)
            $display("FAIL scoreboard_access: got page=%0d wr=%0b nib=%h, required page=%0d wr=%0b nib=%h",
                     got[7:5], got[4], got[3:0], expv[7:5], expv[4], expv[3:0]);
          else
            n_pass++;
        end
      end
    end
  end

  task automatic send_tx(input logic [7:0] b);
    int k = 0;
    while (!TX_READY && k < 1000) begin @(negedge CLK); k++; end
    TX_DATA  = b;
    TX_VALID = 1'b1;
    @(negedge CLK);
    TX_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    n_total++;
    if ({nMCS, nMRD, nMWR, MA0, MD_OUT, MD_OE} !== 9'b111_0_0000_0)
      $display("FAIL reset_bus: got %b, required 111000000", {nMCS, nMRD, nMWR, MA0, MD_OUT, MD_OE});
    else n_pass++;
    n_total++;
    if ({TX_READY, RX_VALID, BUSY} !== 3'b100)
      $display("FAIL reset_flags: got tx_ready/rx_valid/busy=%b, required 100", {TX_READY, RX_VALID, BUSY});
    else n_pass++;
    n_total++;
    if (RX_DATA !== 8'h00) $display("FAIL reset_rx_data: got %h, required 00", RX_DATA);
    else n_pass++;
    RESET = 1'b0;
  endtask

  task automatic test_tx_first();
    int k = 0;
    status = 4'h0;
    sb.push_back({3'd0, 1'b1, 4'h5});
    sb.push_back({3'd1, 1'b1, 4'hA});
    send_tx(8'hA5);
    n_total++;
    if (TX_READY !== 1'b0) $display("FAIL tx_accept_ready: got %b, required 0", TX_READY);
    else n_pass++;
    while (!(sb.size() == 0 && TX_READY) && k < 600) begin @(negedge CLK); k++; end
    n_total++;
    if (sb.size() != 0 || TX_READY !== 1'b1)
      $display("FAIL tx_first_done: got pending=%0d tx_ready=%b, required 0 and 1", sb.size(), TX_READY);
    else n_pass++;
  endtask

  task automatic test_tx_blocked();
    int k = 0;
    int p0, d0;
    status = 4'b0010;
    p0 = poll_count;
    d0 = data_ops;
    send_tx(8'h3C);
    while (poll_count < p0 + 3 && k < 400) begin @(negedge CLK); k++; end
    n_total++;
    if (poll_count < p0 + 3 || data_ops != d0 || TX_READY !== 1'b0)
      $display("FAIL tx_blocked: got polls=%0d data_ops=%0d tx_ready=%b, required polls>=%0d data_ops=%0d tx_ready=0",
               poll_count - p0, data_ops - d0, TX_READY, 3, 0);
    else n_pass++;
    sb.push_back({3'd2, 1'b1, 4'hC});
    sb.push_back({3'd3, 1'b1, 4'h3});
    status = 4'b0000;
    k = 0;
    while (!(sb.size() == 0 && TX_READY) && k < 600) begin @(negedge CLK); k++; end
    n_total++;
    if (sb.size() != 0 || TX_READY !== 1'b1)
      $display("FAIL tx_half_b_done: got pending=%0d tx_ready=%b, required 0 and 1", sb.size(), TX_READY);
    else n_pass++;
  endtask

  task automatic test_rx();
    int k = 0;
    int d0;
    status = 4'b0100;
    nib[0] = 4'h7;
    nib[1] = 4'h2;
    RX_READY = 1'b0;
    sb.push_back({3'd0, 1'b0, 4'h7});
    sb.push_back({3'd1, 1'b0, 4'h2});
    while (!RX_VALID && k < 600) begin @(negedge CLK); k++; end
    n_total++;
    if (RX_VALID !== 1'b1 || RX_DATA !== 8'h27)
      $display("FAIL rx_data: got valid=%b data=%h, required valid=1 data=27", RX_VALID, RX_DATA);
    else n_pass++;
    d0 = data_ops;
    repeat (200) @(negedge CLK);
    n_total++;
    if (data_ops != d0 || RX_VALID !== 1'b1 || sb.size() != 0)
      $display("FAIL rx_no_overrun: got extra_ops=%0d valid=%b pending=%0d, required 0 1 0", data_ops - d0, RX_VALID, sb.size());
    else n_pass++;
    status = 4'b0000;
    RX_READY = 1'b1;
    @(negedge CLK);
    RX_READY = 1'b0;
    n_total++;
    if (RX_VALID !== 1'b0) $display("FAIL rx_consume: got valid=%b, required 0", RX_VALID);
    else n_pass++;
  endtask

  task automatic test_srst_during_tx();
    int k = 0;
    int gap = 0;
    status = 4'b0000;
    sb.push_back({3'd0, 1'b1, 4'h6});
    sb.push_back({3'd1, 1'b1, 4'h9});
    sb.push_back({3'd4, 1'b1, 4'h1});
    sb.push_back({3'd4, 1'b1, 4'h0});
    send_tx(8'h96);
    while (!(!nMWR && MA0 && MD_OUT == 4'h9) && k < 600) begin @(negedge CLK); k++; end
    n_total++;
    if (k >= 600) $display("FAIL srst_tx_hi_seen: got timeout, required TX_HI data write");
    else n_pass++;
    SRST_REQ = 1'b1;
    @(negedge CLK);
    SRST_REQ = 1'b0;
    k = 0;
    while (!(!nMWR && MA0 && MD_OUT == 4'h1 && page_m == 4'd4) && k < 600) begin @(negedge CLK); k++; end
    n_total++;
    if (k >= 600) $display("FAIL srst_set_seen: got timeout, required page 4 write 1");
    else n_pass++;
    k = 0;
    while (!nMCS && k < 20) begin @(negedge CLK); k++; end
    while (nMCS && gap < 300) begin gap++; @(negedge CLK); end
    n_total++;
    if (gap != HOLD + 1) $display("FAIL srst_hold_gap: got %0d released cycles, required %0d", gap, HOLD + 1);
    else n_pass++;
    k = 0;
    while (!(sb.size() == 0 && !BUSY) && k < 300) begin @(negedge CLK); k++; end
    n_total++;
    if (sb.size() != 0 || BUSY !== 1'b0 || TX_READY !== 1'b1)
      $display("FAIL srst_done: got pending=%0d busy=%b tx_ready=%b, required 0 0 1", sb.size(), BUSY, TX_READY);
    else n_pass++;
  endtask

  task automatic test_rx_before_tx();
    int k = 0;
    int p0;
    status = 4'b0001;
    nib[0] = 4'hE;
    nib[1] = 4'h1;
    send_tx(8'h5D);
    p0 = poll_count;
    while (poll_count < p0 + 1 && k < 400) begin @(negedge CLK); k++; end
    n_total++;
    if (poll_count < p0 + 1 || TX_READY !== 1'b0)
      $display("FAIL prio_tx_held: got polls=%0d tx_ready=%b, required polls>=1 tx_ready=0", poll_count - p0, TX_READY);
    else n_pass++;
    sb.push_back({3'd0, 1'b0, 4'hE});
    sb.push_back({3'd1, 1'b0, 4'h1});
    sb.push_back({3'd0, 1'b1, 4'hD});
    sb.push_back({3'd1, 1'b1, 4'h5});
    status = 4'b0100;
    k = 0;
    while (!(sb.size() == 0 && TX_READY) && k < 800) begin @(negedge CLK); k++; end
    n_total++;
    if (sb.size() != 0 || TX_READY !== 1'b1 || RX_VALID !== 1'b1 || RX_DATA !== 8'h1E)
      $display("FAIL prio_done: got pending=%0d tx_ready=%b rx_valid=%b rx_data=%h, required 0 1 1 1e",
               sb.size(), TX_READY, RX_VALID, RX_DATA);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int k = 0;
    status = 4'hF;
    send_tx(8'h77);
    n_total++;
    if (TX_READY !== 1'b0) $display("FAIL midrst_tx_pending: got tx_ready=%b, required 0", TX_READY);
    else n_pass++;
    while (nMRD && k < 400) begin @(negedge CLK); k++; end
    n_total++;
    if (nMRD !== 1'b0) $display("FAIL midrst_read_seen: got nMRD=%b, required 0", nMRD);
    else n_pass++;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    n_total++;
    if ({nMCS, nMRD, nMWR} !== 3'b111)
      $display("FAIL midrst_bus: got nMCS/nMRD/nMWR=%b, required 111", {nMCS, nMRD, nMWR});
    else n_pass++;
    n_total++;
    if ({RX_VALID, TX_READY, BUSY} !== 3'b010)
      $display("FAIL midrst_flags: got rx_valid/tx_ready/busy=%b, required 010", {RX_VALID, TX_READY, BUSY});
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b0;
    status = 4'h0;
    repeat (60) @(negedge CLK);
    n_total++;
    if (sb.size() != 0) $display("FAIL final_scoreboard: got pending=%0d, required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) nib[i] = 4'h0;
    test_reset();
    test_tx_first();
    test_tx_blocked();
    test_rx();
    test_srst_during_tx();
    test_rx_before_tx();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/pc060ha_master_sequencer.md
Name: pc060ha_master_sequencer

Overview:
Master-side bus sequencer for the PC060HA nibble mailbox. It turns byte-wide host TX/RX handshakes into PC060HA master-port cycles: page-register writes, nibble data writes/reads and status polls. It alternates between slot halves A (slots 0/1) and B (slots 2/3), and issues slave-reset commands. It sits between the main-CPU glue logic and the PC060HA master pins (nMCS/nMRD/nMWR/MA0/MD).

Parameters:
STROBE_CYCLES, 2, cycles nMRD/nMWR held low per bus op (>=1)
POLL_INTERVAL, 16, idle cycles between status polls (>=1)
RESET_HOLD, 64, cycles slave reset stays asserted between set and clear writes

Ports:
CLK  in  1  single clock for all logic
RESET  in  1  synchronous active-high reset
TX_VALID  in  1  host offers byte
TX_DATA  in  8  byte to slave
TX_READY  out  1  holding register empty; byte accepted when TX_VALID&TX_READY
RX_VALID  out  1  received byte available
RX_DATA  out  8  byte from slave
RX_READY  in  1  host consumes byte when RX_VALID&RX_READY
SRST_REQ  in  1  one-cycle pulse: request slave reset
BUSY  out  1  high while any bus op or reset sequence is in progress
nMCS  out  1  chip select, active low
nMRD  out  1  read strobe, active low
nMWR  out  1  write strobe, active low
MA0  out  1  0=page register, 1=data register
MD_OUT  out  4  write data
MD_OE  out  1  drive MD_OUT onto MD bus
MD_IN  in  4  read data from MD bus

Behaviour:
- Reset (RESET=1 at edge): nMCS=nMRD=nMWR=1, MA0=0, MD_OUT=0, MD_OE=0, TX_READY=1, RX_VALID=0, RX_DATA=0, BUSY=0. Holding register, SRST sticky, tx_half=rx_half=A and poll counter all cleared. If RESET arrives mid-op, the bus is released on the same edge; no partial op completes.
- Bus op, S=STROBE_CYCLES:
  - cycle 0 SETUP: nMCS=0; MA0 and MD_OUT valid; MD_OE=1 for writes.
  - cycles 1..S STROBE: nMWR or nMRD low.
  - cycle S+1 HOLD: strobe high, nMCS=0, MD_OE unchanged.
  - cycle S+2 GAP: all released.
  - Total S+3 cycles. Reads sample MD_IN on the last STROBE cycle.
- Access = page write (MA0=0, MD_OUT={0,page}) followed by data op (MA0=1). The page is always written before each data op and never relies on page state left in the chip.
- States: IDLE, POLL, RX_LO, RX_HI, TX_LO, TX_HI, SR_SET, SR_WAIT, SR_CLR.
- IDLE: poll counter increments. Go to POLL when counter >= POLL_INTERVAL-1 and (holding reg full or RX_VALID=0 or SRST sticky). Counter clears on entering POLL.
- POLL: page 4 read; latch status st[3:0]={slave_full,slave_half,master_full,master_half}.
- Decision after POLL, highest priority first:
  1. SRST sticky -> SR_SET.
  2. RX_VALID=0 and st[rx_half?3:2]=1 -> RX_LO.
  3. Holding reg full and st[tx_half?1:0]=0 -> TX_LO.
  4. Otherwise -> IDLE.
- TX_LO: page (A:0, B:2), write TX[3:0]. TX_HI: page (A:1, B:3), write TX[7:4]. The second write sets the chip flag. On completion: holding reg empty, TX_READY=1, tx_half toggles, -> IDLE.
- RX_LO: page (A:0, B:2), read low nibble. RX_HI: page (A:1, B:3), read high nibble; this read clears the flag. On completion: RX_DATA={hi,lo}, RX_VALID=1, rx_half toggles, -> IDLE.
- RX_VALID stays high until RX_READY=1 at an edge. No RX op starts while RX_VALID=1, so no overrun.
- TX_VALID&TX_READY latches TX_DATA in any state; TX_READY drops on the next edge.
- SRST_REQ sets the sticky bit at any time; it is serviced only at the POLL decision, never mid-op.
  - SR_SET: page 4, write 0x1.
  - SR_WAIT: RESET_HOLD cycles, bus idle.
  - SR_CLR: page 4, write 0x0.
  - Then: sticky cleared, tx_half=rx_half=A. A pending TX byte is kept and RX_VALID/RX_DATA are unaffected.
- BUSY=1 in every state except IDLE.

Test Plan:
- Reset then TX 0xA5, status reads 0x0 -> bus shows page write 0, data write 0x5, page write 1, data write 0xA in that order. Each op is 5 cycles for S=2. TX_READY returns to 1, and tx_half=B.
- Second TX 0x3C with st[1]=1 for 3 polls, then 0 -> no data write while st[1]=1. Then pages 2/3 carry 0xC and 0x3.
- Status 0x4 with MD_IN returning 0x7 then 0x2 -> RX_DATA=0x27, RX_VALID=1. With RX_READY held 0, later polls perform no further RX reads.
- TX pending and st=0x4 on the same poll -> RX executes first; TX follows after the next poll.
- SRST_REQ pulsed during a TX_HI op -> the op completes unaltered. Then page 4 write 0x1, 64 idle cycles, page 4 write 0x0, and both halves return to A.
- RESET asserted during the STROBE of a read -> nMCS, nMRD and nMWR are all 1 on the next edge. RX_VALID=0 and TX_READY=1.
